// File: rtl/axi_arb_pkg.sv
// Shared types, constants and the round-robin pick function used by the
// write-path arbiter. A future read arbiter reuses the same pieces.
package axi_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } arb_state_e;

  // Upper two ID bits carry the requester index on the shared channel.
  localparam int ID_TAG_LSB = 6;

  // Largest requester count the tag field can address.
  localparam int MAX_M = 4;

  // First requesting index at or after ptr, wrapping modulo n (n <= MAX_M).
  // Returns 0 when nothing is requesting; callers qualify with |req.
  function automatic logic [1:0] rr_pick(input logic [MAX_M-1:0] req,
                                         input logic [1:0]       ptr,
                                         input int               n);
    logic [1:0] pick;
    logic       found;
    int         idx;
    logic [1:0] idx2;
    pick  = 2'd0;
    found = 1'b0;
    for (int k = 0; k < MAX_M; k++) begin
      idx  = (int'(ptr) + k) % n;
      idx2 = idx[1:0];
      if ((k < n) && !found && req[idx2]) begin
        pick  = idx2;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/axi_wr_arbiter_if.sv
// Bundle of the per-requester AXI write channels (packed, requester i at
// slice i) and the single shared write channel toward the master driver.
// The master modport is the arbiter's view; slave is the surrounding agent.
interface axi_wr_arbiter_if #(
  parameter int NUM_M      = 2,
  parameter int DATA_WIDTH = 32,
  parameter int ADD_WIDTH  = 32
);

  // Requester-side AW
  logic [NUM_M*8-1:0]            s_awid;
  logic [NUM_M*ADD_WIDTH-1:0]    s_awaddr;
  logic [NUM_M*8-1:0]            s_awlen;
  logic [NUM_M*3-1:0]            s_awsize;
  logic [NUM_M*2-1:0]            s_awburst;
  logic [NUM_M-1:0]              s_awvalid;
  logic [NUM_M-1:0]              s_awready;
  // Requester-side W
  logic [NUM_M*DATA_WIDTH-1:0]   s_wdata;
  logic [NUM_M*DATA_WIDTH/8-1:0] s_wstrb;
  logic [NUM_M-1:0]              s_wlast;
  logic [NUM_M-1:0]              s_wvalid;
  logic [NUM_M-1:0]              s_wready;
  // Requester-side B
  logic [NUM_M*8-1:0]            s_bid;
  logic [NUM_M*2-1:0]            s_bresp;
  logic [NUM_M-1:0]              s_bvalid;
  logic [NUM_M-1:0]              s_bready;

  // Shared AW
  logic [7:0]                    m_awid;
  logic [ADD_WIDTH-1:0]          m_awaddr;
  logic [7:0]                    m_awlen;
  logic [2:0]                    m_awsize;
  logic [1:0]                    m_awburst;
  logic                          m_awvalid;
  logic                          m_awready;
  // Shared W
  logic [7:0]                    m_wid;
  logic [DATA_WIDTH-1:0]         m_wdata;
  logic [DATA_WIDTH/8-1:0]       m_wstrb;
  logic                          m_wlast;
  logic                          m_wvalid;
  logic                          m_wready;
  // Shared B
  logic [7:0]                    m_bid;
  logic [1:0]                    m_bresp;
  logic                          m_bvalid;
  logic                          m_bready;

  modport master (
    input  s_awid, s_awaddr, s_awlen, s_awsize, s_awburst, s_awvalid,
    output s_awready,
    input  s_wdata, s_wstrb, s_wlast, s_wvalid,
    output s_wready,
    output s_bid, s_bresp, s_bvalid,
    input  s_bready,
    output m_awid, m_awaddr, m_awlen, m_awsize, m_awburst, m_awvalid,
    input  m_awready,
    output m_wid, m_wdata, m_wstrb, m_wlast, m_wvalid,
    input  m_wready,
    input  m_bid, m_bresp, m_bvalid,
    output m_bready
  );

  modport slave (
    output s_awid, s_awaddr, s_awlen, s_awsize, s_awburst, s_awvalid,
    input  s_awready,
    output s_wdata, s_wstrb, s_wlast, s_wvalid,
    input  s_wready,
    input  s_bid, s_bresp, s_bvalid,
    output s_bready,
    input  m_awid, m_awaddr, m_awlen, m_awsize, m_awburst, m_awvalid,
    output m_awready,
    input  m_wid, m_wdata, m_wstrb, m_wlast, m_wvalid,
    output m_wready,
    output m_bid, m_bresp, m_bvalid,
    input  m_bready
  );

endinterface

// File: rtl/axi_rr_picker.sv
// Combinational round-robin priority encoder: picks the first asserted
// request at or after ptr, wrapping at NUM_M.
module axi_rr_picker
  import axi_arb_pkg::*;
#(
  parameter int NUM_M = 2
) (
  input  logic [NUM_M-1:0] req,
  input  logic [1:0]       ptr,
  output logic [1:0]       pick,
  output logic             valid
);

  logic [MAX_M-1:0] req_ext;

  // Zero-extend the request vector to the width the pick function expects
  always_comb begin
    req_ext            = '0;
    req_ext[NUM_M-1:0] = req;
  end

  assign pick  = rr_pick(req_ext, ptr, NUM_M);
  assign valid = |req;

endmodule

// File: rtl/axi_wr_arbiter.sv
// Round-robin arbiter sharing one AXI write path among NUM_M requesters.
// AW is registered after a one-cycle arbitration, the grant is held until
// the W burst's last beat, and B is steered back by the ID tag bits.
module axi_wr_arbiter
  import axi_arb_pkg::*;
#(
  parameter int NUM_M      = 2,
  parameter int DATA_WIDTH = 32,
  parameter int ADD_WIDTH  = 32
) (
  input  logic             aclk,
  input  logic             areset,
  axi_wr_arbiter_if.master bus,
  output logic             err_len,
  output logic             err_bid
);

  localparam int STRB_W = DATA_WIDTH / 8;

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_ADDR = ADDR;
  localparam logic [1:0] S_DATA = DATA;

  logic [1:0]            state_reg;
  logic [1:0]            grant_reg;
  logic [1:0]            rr_ptr_reg;
  logic [7:0]            beat_cnt_reg;
  logic [7:0]            awid_reg;
  logic [ADD_WIDTH-1:0]  awaddr_reg;
  logic [7:0]            awlen_reg;
  logic [2:0]            awsize_reg;
  logic [1:0]            awburst_reg;
  logic                  err_len_reg;
  logic                  err_bid_reg;

  logic [1:0]            pick_idx;
  logic                  pick_valid;
  logic [ID_TAG_LSB-1:0] pick_id;
  logic [ADD_WIDTH-1:0]  pick_addr;
  logic [7:0]            pick_len;
  logic [2:0]            pick_size;
  logic [1:0]            pick_burst;

  logic                  sel_wvalid;
  logic                  sel_wlast;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic [STRB_W-1:0]     sel_wstrb;

  logic                  in_addr;
  logic                  in_data;
  logic                  aw_hs;
  logic                  w_hs;
  logic                  cnt_zero;
  logic [1:0]            grant_inc;
  logic [1:0]            b_tag;
  logic                  bid_ok;
  logic                  m_bready_v;
  logic [NUM_M-1:0]      s_awready_v;
  logic [NUM_M-1:0]      s_wready_v;
  logic [NUM_M-1:0]      s_bvalid_v;

  axi_rr_picker #(.NUM_M(NUM_M)) u_picker (
    .req   (bus.s_awvalid),
    .ptr   (rr_ptr_reg),
    .pick  (pick_idx),
    .valid (pick_valid)
  );

  // AW fields of the requester the picker is currently pointing at
  always_comb begin
    pick_id    = '0;
    pick_addr  = '0;
    pick_len   = '0;
    pick_size  = '0;
    pick_burst = '0;
    for (int i = 0; i < NUM_M; i++) begin
      if (pick_idx == 2'(i)) begin
        pick_id    = bus.s_awid[i*8 +: ID_TAG_LSB];
        pick_addr  = bus.s_awaddr[i*ADD_WIDTH +: ADD_WIDTH];
        pick_len   = bus.s_awlen[i*8 +: 8];
        pick_size  = bus.s_awsize[i*3 +: 3];
        pick_burst = bus.s_awburst[i*2 +: 2];
      end
    end
  end

  // W fields of the granted requester
  always_comb begin
    sel_wvalid = 1'b0;
    sel_wlast  = 1'b0;
    sel_wdata  = '0;
    sel_wstrb  = '0;
    for (int i = 0; i < NUM_M; i++) begin
      if (grant_reg == 2'(i)) begin
        sel_wvalid = bus.s_wvalid[i];
        sel_wlast  = bus.s_wlast[i];
        sel_wdata  = bus.s_wdata[i*DATA_WIDTH +: DATA_WIDTH];
        sel_wstrb  = bus.s_wstrb[i*STRB_W +: STRB_W];
      end
    end
  end

  assign in_addr   = (state_reg == S_ADDR);
  assign in_data   = (state_reg == S_DATA);
  assign aw_hs     = in_addr & bus.m_awready;
  assign w_hs      = in_data & sel_wvalid & bus.m_wready;
  assign cnt_zero  = (beat_cnt_reg == 8'd0);
  assign grant_inc = grant_reg + 2'd1;

  // Ready back to the granted requester only; everyone else sees 0
  always_comb begin
    s_awready_v = '0;
    s_wready_v  = '0;
    for (int i = 0; i < NUM_M; i++) begin
      if (grant_reg == 2'(i)) begin
        s_awready_v[i] = aw_hs;
        s_wready_v[i]  = in_data & bus.m_wready;
      end
    end
  end

  assign b_tag = bus.m_bid[ID_TAG_LSB +: 2];

  // B steering by ID tag; an unknown tag is drained so the slave never stalls
  always_comb begin
    s_bvalid_v = '0;
    m_bready_v = 1'b1;
    bid_ok     = 1'b0;
    for (int i = 0; i < NUM_M; i++) begin
      if (b_tag == 2'(i)) begin
        bid_ok        = 1'b1;
        s_bvalid_v[i] = bus.m_bvalid;
        m_bready_v    = bus.s_bready[i];
      end
    end
  end

  assign bus.s_awready = s_awready_v;
  assign bus.s_wready  = s_wready_v;
  // Held low while reset is asserted so no response is lost during reset
  assign bus.s_bvalid  = s_bvalid_v & {NUM_M{areset}};
  assign bus.m_bready  = m_bready_v & areset;
  assign bus.s_bid     = {NUM_M{{2'b00, bus.m_bid[ID_TAG_LSB-1:0]}}};
  assign bus.s_bresp   = {NUM_M{bus.m_bresp}};

  assign bus.m_awvalid = in_addr;
  assign bus.m_awid    = awid_reg;
  assign bus.m_awaddr  = awaddr_reg;
  assign bus.m_awlen   = awlen_reg;
  assign bus.m_awsize  = awsize_reg;
  assign bus.m_awburst = awburst_reg;

  assign bus.m_wvalid  = in_data & sel_wvalid;
  assign bus.m_wid     = awid_reg;
  assign bus.m_wdata   = sel_wdata;
  assign bus.m_wstrb   = sel_wstrb;
  // The counted last beat is always marked last, whatever the requester says
  assign bus.m_wlast   = in_data & (sel_wlast | cnt_zero);

  assign err_len = err_len_reg;
  assign err_bid = err_bid_reg;

  // Arbitration FSM: IDLE picks and captures AW, ADDR issues it, DATA forwards W
  always_ff @(posedge aclk or negedge areset) begin
    if (!areset) begin
      state_reg    <= S_IDLE;
      grant_reg    <= 2'd0;
      rr_ptr_reg   <= 2'd0;
      beat_cnt_reg <= 8'd0;
      awid_reg     <= 8'd0;
      awaddr_reg   <= '0;
      awlen_reg    <= 8'd0;
      awsize_reg   <= 3'd0;
      awburst_reg  <= 2'd0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (pick_valid) begin
            grant_reg   <= pick_idx;
            awid_reg    <= {pick_idx, pick_id};
            awaddr_reg  <= pick_addr;
            awlen_reg   <= pick_len;
            awsize_reg  <= pick_size;
            awburst_reg <= pick_burst;
            state_reg   <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (aw_hs) begin
            rr_ptr_reg   <= (grant_inc == 2'(NUM_M)) ? 2'd0 : grant_inc;
            beat_cnt_reg <= awlen_reg;
            state_reg    <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_hs) begin
            beat_cnt_reg <= beat_cnt_reg - 8'd1;
            if (sel_wlast) begin
              state_reg <= S_IDLE;
            end
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  // Sticky debug flags for burst-length and B-tag protocol violations
  always_ff @(posedge aclk or negedge areset) begin
    if (!areset) begin
      err_len_reg <= 1'b0;
      err_bid_reg <= 1'b0;
    end else begin
      if (w_hs && (sel_wlast != cnt_zero)) begin
        err_len_reg <= 1'b1;
      end
      if (bus.m_bvalid && !bid_ok) begin
        err_bid_reg <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Directed bench for axi_wr_arbiter with two requesters.
module tb_axi_wr_arbiter;

  localparam int NM = 2;
  localparam int DW = 32;
  localparam int AW = 32;

  logic aclk;
  logic areset;
  logic err_len;
  logic err_bid;
  int   total;
  int   bad;

  axi_wr_arbiter_if #(.NUM_M(NM), .DATA_WIDTH(DW), .ADD_WIDTH(AW)) bus ();

  axi_wr_arbiter #(.NUM_M(NM), .DATA_WIDTH(DW), .ADD_WIDTH(AW)) dut (
    .aclk    (aclk),
    .areset  (areset),
    .bus     (bus),
    .err_len (err_len),
    .err_bid (err_bid)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic clear_inputs();
    bus.s_awid    = '0;
    bus.s_awaddr  = '0;
    bus.s_awlen   = '0;
    bus.s_awsize  = '0;
    bus.s_awburst = '0;
    bus.s_awvalid = '0;
    bus.s_wdata   = '0;
    bus.s_wstrb   = '0;
    bus.s_wlast   = '0;
    bus.s_wvalid  = '0;
    bus.s_bready  = '0;
    bus.m_awready = 1'b0;
    bus.m_wready  = 1'b0;
    bus.m_bid     = 8'h00;
    bus.m_bresp   = 2'b00;
    bus.m_bvalid  = 1'b0;
  endtask

  task automatic aw_set(input int r, input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len);
    bus.s_awid[r*8 +: 8]     = id;
    bus.s_awaddr[r*AW +: AW] = addr;
    bus.s_awlen[r*8 +: 8]    = len;
    bus.s_awsize[r*3 +: 3]   = 3'd2;
    bus.s_awburst[r*2 +: 2]  = 2'd1;
    bus.s_awvalid[r]         = 1'b1;
  endtask

  // Wait for m_awvalid, check the issued AW against grant g, then accept it
  task automatic aw_accept(input string tag, input int g, input logic [7:0] id,
                           input logic [31:0] addr, input logic [7:0] len);
    int waited;
    waited = 0;
    while (!bus.m_awvalid && waited < 20) begin
      @(negedge aclk);
      #1;
      waited++;
    end
    check({tag, "_aw_latency"}, 64'(waited), 64'd1);
    check({tag, "_awid"}, 64'(bus.m_awid), 64'({g[1:0], id[5:0]}));
    check({tag, "_awaddr"}, 64'(bus.m_awaddr), 64'(addr));
    check({tag, "_awlen"}, 64'(bus.m_awlen), 64'(len));
    bus.m_awready = 1'b1;
    #1;
    check({tag, "_s_awready"}, 64'(bus.s_awready), 64'(2'b01 << g));
    @(negedge aclk);
    bus.m_awready    = 1'b0;
    bus.s_awvalid[g] = 1'b0;
    #1;
    check({tag, "_awvalid_after"}, 64'(bus.m_awvalid), 64'd0);
  endtask

  // Forward n beats from requester g with s_wlast on the final beat
  task automatic w_burst(input string tag, input int g, input int n, input logic [31:0] base,
                         input logic [7:0] exp_id);
    for (int b = 0; b < n; b++) begin
      bus.s_wvalid[g]         = 1'b1;
      bus.s_wdata[g*DW +: DW] = base + 32'(b);
      bus.s_wstrb[g*4 +: 4]   = 4'hF;
      bus.s_wlast[g]          = (b == n - 1);
      bus.m_wready            = 1'b1;
      #1;
      check($sformatf("%s_b%0d_wvalid", tag, b), 64'(bus.m_wvalid), 64'd1);
      check($sformatf("%s_b%0d_wdata", tag, b), 64'(bus.m_wdata), 64'(base + 32'(b)));
      check($sformatf("%s_b%0d_wlast", tag, b), 64'(bus.m_wlast), 64'(b == n - 1));
      check($sformatf("%s_b%0d_wready", tag, b), 64'(bus.s_wready), 64'(2'b01 << g));
      check($sformatf("%s_b%0d_wid", tag, b), 64'(bus.m_wid), 64'(exp_id));
      check($sformatf("%s_b%0d_awvalid", tag, b), 64'(bus.m_awvalid), 64'd0);
      @(negedge aclk);
    end
    bus.s_wvalid[g] = 1'b0;
    bus.s_wlast[g]  = 1'b0;
    bus.m_wready    = 1'b0;
    #1;
    check({tag, "_wvalid_after"}, 64'(bus.m_wvalid), 64'd0);
  endtask

  task automatic do_reset(input string tag);
    areset = 1'b0;
    #1;
    check({tag, "_awvalid"}, 64'(bus.m_awvalid), 64'd0);
    check({tag, "_wvalid"}, 64'(bus.m_wvalid), 64'd0);
    check({tag, "_bready"}, 64'(bus.m_bready), 64'd0);
    check({tag, "_s_bvalid"}, 64'(bus.s_bvalid), 64'd0);
    check({tag, "_s_awready"}, 64'(bus.s_awready), 64'd0);
    check({tag, "_s_wready"}, 64'(bus.s_wready), 64'd0);
    @(negedge aclk);
    areset = 1'b1;
    #1;
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    areset = 1'b0;
    clear_inputs();
    // Drive B inputs during reset to show the outputs stay gated
    bus.m_bvalid = 1'b1;
    bus.s_bready = 2'b11;
    repeat (2) @(negedge aclk);
    do_reset("reset");
    bus.m_bvalid = 1'b0;
    bus.s_bready = 2'b00;
    check("reset_err_len", 64'(err_len), 64'd0);
    check("reset_err_bid", 64'(err_bid), 64'd0);

    // 1) single requester, len=3
    aw_set(0, 8'h12, 32'h100, 8'd3);
    #1;
    check("t1_awvalid_idle", 64'(bus.m_awvalid), 64'd0);
    aw_accept("t1", 0, 8'h12, 32'h100, 8'd3);
    w_burst("t1", 0, 4, 32'hA0, 8'h12);
    check("t1_err_len", 64'(err_len), 64'd0);

    // 2) both request at rr_ptr=0: req0, req1, then req0 again
    do_reset("t2_reset");
    aw_set(0, 8'h03, 32'h200, 8'd1);
    aw_set(1, 8'h04, 32'h300, 8'd1);
    aw_accept("t2a", 0, 8'h03, 32'h200, 8'd1);
    check("t2a_s_awready_req1", 64'(bus.s_awready), 64'd0);
    w_burst("t2a", 0, 2, 32'hB0, 8'h03);
    aw_accept("t2b", 1, 8'h04, 32'h300, 8'd1);
    w_burst("t2b", 1, 2, 32'hC0, 8'h44);
    aw_set(0, 8'h05, 32'h400, 8'd0);
    aw_set(1, 8'h06, 32'h500, 8'd0);
    aw_accept("t2c", 0, 8'h05, 32'h400, 8'd0);
    w_burst("t2c", 0, 1, 32'hD0, 8'h05);
    aw_accept("t2d", 1, 8'h06, 32'h500, 8'd0);
    w_burst("t2d", 1, 1, 32'hE0, 8'h46);

    // 3) m_awready held low 5 cycles; fields registered and stable
    aw_set(1, 8'h09, 32'h600, 8'd0);
    @(negedge aclk);
    #1;
    bus.s_awaddr[AW +: AW] = 32'hDEAD;
    for (int c = 0; c < 5; c++) begin
      check($sformatf("t3_hold%0d_awvalid", c), 64'(bus.m_awvalid), 64'd1);
      check($sformatf("t3_hold%0d_awaddr", c), 64'(bus.m_awaddr), 64'h600);
      check($sformatf("t3_hold%0d_s_awready", c), 64'(bus.s_awready), 64'd0);
      @(negedge aclk);
      #1;
    end
    bus.m_awready = 1'b1;
    #1;
    check("t3_s_awready_pulse", 64'(bus.s_awready), 64'b10);
    @(negedge aclk);
    bus.m_awready = 1'b0;
    bus.s_awvalid = 2'b00;
    #1;
    check("t3_s_awready_gone", 64'(bus.s_awready), 64'd0);
    w_burst("t3", 1, 1, 32'hF0, 8'h49);

    // 4) B to requester 1, held off by s_bready[1]
    bus.m_bid    = 8'h45;
    bus.m_bresp  = 2'b10;
    bus.m_bvalid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      bus.s_bready = (c == 1) ? 2'b01 : 2'b00;
      #1;
      check($sformatf("t4_c%0d_s_bvalid", c), 64'(bus.s_bvalid), 64'b10);
      check($sformatf("t4_c%0d_s_bid1", c), 64'(bus.s_bid[15:8]), 64'h05);
      check($sformatf("t4_c%0d_s_bresp1", c), 64'(bus.s_bresp[3:2]), 64'b10);
      check($sformatf("t4_c%0d_m_bready", c), 64'(bus.m_bready), 64'd0);
      @(negedge aclk);
    end
    bus.s_bready = 2'b10;
    #1;
    check("t4_m_bready", 64'(bus.m_bready), 64'd1);
    @(negedge aclk);
    bus.m_bvalid = 1'b0;
    bus.s_bready = 2'b00;
    check("t4_err_bid", 64'(err_bid), 64'd0);

    // 5) out-of-range tag is dropped and flagged
    bus.m_bid    = 8'hC1;
    bus.m_bvalid = 1'b1;
    #1;
    check("t5_m_bready", 64'(bus.m_bready), 64'd1);
    check("t5_s_bvalid", 64'(bus.s_bvalid), 64'd0);
    @(negedge aclk);
    bus.m_bvalid = 1'b0;
    bus.m_bid    = 8'h00;
    #1;
    check("t5_err_bid", 64'(err_bid), 64'd1);

    // Length violation: len=1 but s_wlast withheld on the counted last beat
    aw_set(0, 8'h0A, 32'h800, 8'd1);
    aw_accept("tl", 0, 8'h0A, 32'h800, 8'd1);
    bus.s_wvalid[0] = 1'b1;
    bus.m_wready    = 1'b1;
    bus.s_wlast[0]  = 1'b0;
    #1;
    check("tl_b0_wlast", 64'(bus.m_wlast), 64'd0);
    @(negedge aclk);
    #1;
    check("tl_b1_forced_wlast", 64'(bus.m_wlast), 64'd1);
    check("tl_err_before", 64'(err_len), 64'd0);
    @(negedge aclk);
    #1;
    check("tl_err_len", 64'(err_len), 64'd1);
    check("tl_still_data", 64'(bus.m_wvalid), 64'd1);
    bus.s_wlast[0] = 1'b1;
    @(negedge aclk);
    bus.s_wvalid[0] = 1'b0;
    bus.s_wlast[0]  = 1'b0;
    bus.m_wready    = 1'b0;

    // 6) reset during beat 2 of a len=7 burst
    aw_set(0, 8'h07, 32'h700, 8'd7);
    aw_accept("t6", 0, 8'h07, 32'h700, 8'd7);
    bus.s_wvalid[0] = 1'b1;
    bus.s_wdata[31:0] = 32'h70;
    bus.m_wready    = 1'b1;
    @(negedge aclk);
    bus.s_wdata[31:0] = 32'h71;
    #1;
    check("t6_beat2_wvalid", 64'(bus.m_wvalid), 64'd1);
    #1;
    areset = 1'b0;
    #1;
    check("t6_rst_wvalid", 64'(bus.m_wvalid), 64'd0);
    check("t6_rst_awvalid", 64'(bus.m_awvalid), 64'd0);
    check("t6_rst_s_wready", 64'(bus.s_wready), 64'd0);
    clear_inputs();
    @(negedge aclk);
    areset = 1'b1;
    #1;
    check("t6_err_len_clr", 64'(err_len), 64'd0);
    check("t6_err_bid_clr", 64'(err_bid), 64'd0);
    check("t6_idle_awvalid", 64'(bus.m_awvalid), 64'd0);
    aw_set(0, 8'h21, 32'h900, 8'd0);
    aw_set(1, 8'h22, 32'hA00, 8'd0);
    aw_accept("t6a", 0, 8'h21, 32'h900, 8'd0);
    w_burst("t6a", 0, 1, 32'h90, 8'h21);
    aw_accept("t6b", 1, 8'h22, 32'hA00, 8'd0);
    w_burst("t6b", 1, 1, 32'hA0, 8'h62);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
